// File: rtl/card_shoe.sv
// Card source for the blackjack game: deals one card per request from a shoe of
// NUM_DECKS decks without repetition, reshuffling on command or when empty.
module card_shoe #(
   parameter int          NUM_DECKS    = 1,
   parameter int          RESHUFFLE_AT = 15,
   parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       card_req,
   input  logic       shuffle,
   input  logic       test_mode,
   output logic       card_valid,
   output logic [3:0] card_rank,
   output logic [3:0] card_value,
   output logic [1:0] card_suit,
   output logic [8:0] cards_left,
   output logic       need_shuffle,
   output logic       busy
);

   localparam int            TOTAL   = 52 * NUM_DECKS;
   localparam int            CW      = (NUM_DECKS < 2) ? 1 : $clog2(NUM_DECKS + 1);
   localparam logic [CW-1:0] DECKS_C = CW'(NUM_DECKS);
   localparam logic [8:0]    TOTAL_C = 9'(TOTAL);

   typedef enum logic [1:0] {IDLE, SEARCH, DELIVER, SHUFFLE} state_t;

   state_t        state_reg, state_next;
   logic [5:0]    idx_reg, idx_next;
   logic [5:0]    seq_reg;
   logic          pend_reg, pend_next;
   logic          tm_reg, tm_next;
   logic [15:0]   lfsr_reg;
   logic [8:0]    left_reg;
   logic [3:0]    rank_reg, value_reg;
   logic [1:0]    suit_reg;
   logic [CW-1:0] slot_cnt [52];
   logic          hit, shuf_done, avail;
   logic [5:0]    rnd_idx, idx_inc;
   logic [1:0]    dec_suit;
   logic [3:0]    dec_rank;

   assign rnd_idx = (lfsr_reg[5:0] >= 6'd52) ? lfsr_reg[5:0] - 6'd52 : lfsr_reg[5:0];
   assign idx_inc = (idx_reg == 6'd51) ? 6'd0 : idx_reg + 6'd1;
   assign avail   = slot_cnt[idx_reg] < DECKS_C;

   // Slot index = 13*suit + (rank-1)
   always_comb begin
      if (idx_reg < 6'd13) begin
         dec_suit = 2'd0;
         dec_rank = 4'(idx_reg + 6'd1);
      end else if (idx_reg < 6'd26) begin
         dec_suit = 2'd1;
         dec_rank = 4'(idx_reg - 6'd12);
      end else if (idx_reg < 6'd39) begin
         dec_suit = 2'd2;
         dec_rank = 4'(idx_reg - 6'd25);
      end else begin
         dec_suit = 2'd3;
         dec_rank = 4'(idx_reg - 6'd38);
      end
   end

   always_comb begin
      state_next = state_reg;
      idx_next   = idx_reg;
      pend_next  = pend_reg;
      tm_next    = tm_reg;
      hit        = 1'b0;
      shuf_done  = 1'b0;
      case (state_reg)
         IDLE: begin
            if (shuffle) begin
               state_next = SHUFFLE;
               idx_next   = 6'd0;
               pend_next  = 1'b0;
            end else if (card_req && left_reg == 9'd0) begin
               state_next = SHUFFLE;
               idx_next   = 6'd0;
               pend_next  = 1'b1;
            end else if (card_req) begin
               state_next = SEARCH;
               idx_next   = test_mode ? seq_reg : rnd_idx;
               tm_next    = test_mode;
            end
         end
         SEARCH: begin
            if (avail) begin
               hit        = 1'b1;
               state_next = DELIVER;
            end else begin
               idx_next = idx_inc;
            end
         end
         DELIVER: state_next = IDLE;
         SHUFFLE: begin
            if (idx_reg == 6'd51) begin
               shuf_done = 1'b1;
               if (pend_reg) begin
                  // Sequential pointer is being cleared on this same edge
                  state_next = SEARCH;
                  idx_next   = test_mode ? 6'd0 : rnd_idx;
                  tm_next    = test_mode;
                  pend_next  = 1'b0;
               end else begin
                  state_next = IDLE;
               end
            end else begin
               idx_next = idx_reg + 6'd1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg <= IDLE;
         idx_reg   <= 6'd0;
         pend_reg  <= 1'b0;
         tm_reg    <= 1'b0;
      end else begin
         state_reg <= state_next;
         idx_reg   <= idx_next;
         pend_reg  <= pend_next;
         tm_reg    <= tm_next;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         lfsr_reg <= LFSR_SEED;
      end else begin
         lfsr_reg <= {1'b0, lfsr_reg[15:1]} ^ (lfsr_reg[0] ? 16'hB400 : 16'h0000);
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 52; gi++) begin : g_slot
         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               slot_cnt[gi] <= '0;
            end else if (state_reg == SHUFFLE && idx_reg == 6'(gi)) begin
               slot_cnt[gi] <= '0;
            end else if (hit && idx_reg == 6'(gi)) begin
               slot_cnt[gi] <= slot_cnt[gi] + 1'b1;
            end
         end
      end
   endgenerate

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         left_reg  <= TOTAL_C;
         seq_reg   <= 6'd0;
         rank_reg  <= 4'd0;
         value_reg <= 4'd0;
         suit_reg  <= 2'd0;
      end else begin
         if (shuf_done) begin
            left_reg <= TOTAL_C;
            seq_reg  <= 6'd0;
         end else if (hit) begin
            if (left_reg != 9'd0) left_reg <= left_reg - 9'd1;
            if (tm_reg) seq_reg <= idx_inc;
         end
         if (hit) begin
            rank_reg  <= dec_rank;
            value_reg <= (dec_rank > 4'd10) ? 4'd10 : dec_rank;
            suit_reg  <= dec_suit;
         end
      end
   end

   assign card_valid   = (state_reg == DELIVER);
   assign busy         = (state_reg != IDLE);
   assign card_rank    = rank_reg;
   assign card_value   = value_reg;
   assign card_suit    = suit_reg;
   assign cards_left   = left_reg;
   assign need_shuffle = (32'(left_reg) < RESHUFFLE_AT);

endmodule

// File: tb/tb_card_shoe.sv
// Directed bench for card_shoe: sequential dealing, exhaustion, random uniqueness,
// shuffle priority, ignored requests and asynchronous reset.
module tb_card_shoe;
   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       card_req = 1'b0;
   logic       shuffle = 1'b0;
   logic       test_mode = 1'b1;
   logic       card_valid;
   logic [3:0] card_rank;
   logic [3:0] card_value;
   logic [1:0] card_suit;
   logic [8:0] cards_left;
   logic       need_shuffle;
   logic       busy;

   int n_tests = 0;
   int n_fail  = 0;

   card_shoe dut (
      .clk(clk), .reset(reset), .card_req(card_req), .shuffle(shuffle),
      .test_mode(test_mode), .card_valid(card_valid), .card_rank(card_rank),
      .card_value(card_value), .card_suit(card_suit), .cards_left(cards_left),
      .need_shuffle(need_shuffle), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Issues one request and returns the number of cycles until card_valid
   task automatic deal(output int lat);
      @(negedge clk);
      card_req = 1'b1;
      @(negedge clk);
      card_req = 1'b0;
      lat = 1;
      while (!card_valid && lat < 200) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
   endtask

   initial begin
      int lat, exp_rank, exp_val, s, nbusy, nvalid, nseen;
      logic [3:0] saved_rank;
      logic [1:0] saved_suit;
      logic [51:0] seen;

      // Reset state
      #12;
      check("rst_valid", card_valid, 0);
      check("rst_rank", card_rank, 0);
      check("rst_value", card_value, 0);
      check("rst_suit", card_suit, 0);
      check("rst_left", cards_left, 52);
      check("rst_need", need_shuffle, 0);
      check("rst_busy", busy, 0);
      @(negedge clk);
      reset = 1'b1;

      // Sequential deal of the whole deck
      test_mode = 1'b1;
      for (int i = 0; i < 52; i++) begin
         deal(lat);
         exp_rank = (i % 13) + 1;
         exp_val  = (exp_rank > 10) ? 10 : exp_rank;
         check($sformatf("seq%0d_lat", i), lat, 2);
         check($sformatf("seq%0d_rank", i), card_rank, exp_rank);
         check($sformatf("seq%0d_value", i), card_value, exp_val);
         check($sformatf("seq%0d_suit", i), card_suit, i / 13);
         check($sformatf("seq%0d_left", i), cards_left, 51 - i);
         check($sformatf("seq%0d_need", i), need_shuffle, (51 - i) < 15);
         $display("[TB] seq deal %0d rank=%0d suit=%0d left=%0d", i, card_rank, card_suit, cards_left);
      end
      check("empty_left", cards_left, 0);
      check("empty_need", need_shuffle, 1);

      // Empty shoe: auto reshuffle then deal
      deal(lat);
      check("auto_lat", lat, 54);
      check("auto_rank", card_rank, 1);
      check("auto_suit", card_suit, 0);
      check("auto_left", cards_left, 51);
      $display("[TB] auto-reshuffle deal lat=%0d rank=%0d left=%0d", lat, card_rank, cards_left);

      // Random deal: every card exactly once
      do_reset();
      test_mode = 1'b0;
      seen = '0;
      for (int i = 0; i < 52; i++) begin
         deal(lat);
         s = 13 * int'(card_suit) + int'(card_rank) - 1;
         check($sformatf("rnd%0d_lat_ok", i), (lat >= 2 && lat <= 53), 1);
         check($sformatf("rnd%0d_rank_ok", i), (card_rank >= 1 && card_rank <= 13), 1);
         if (s >= 0 && s < 52) begin
            check($sformatf("rnd%0d_new", i), seen[s], 0);
            seen[s] = 1'b1;
         end
         check($sformatf("rnd%0d_left", i), cards_left, 51 - i);
         check($sformatf("rnd%0d_need", i), need_shuffle, (51 - i) < 15);
         $display("[TB] rnd deal %0d rank=%0d suit=%0d left=%0d lat=%0d", i, card_rank, card_suit, cards_left, lat);
      end
      nseen = $countones(seen);
      check("rnd_all_seen", nseen, 52);

      // Shuffle has priority over a simultaneous request
      do_reset();
      test_mode = 1'b1;
      for (int i = 0; i < 5; i++) deal(lat);
      saved_rank = card_rank;
      saved_suit = card_suit;
      check("pri_pre_rank", saved_rank, 5);
      check("pri_pre_left", cards_left, 47);
      @(negedge clk);
      shuffle = 1'b1;
      card_req = 1'b1;
      @(negedge clk);
      shuffle = 1'b0;
      card_req = 1'b0;
      nbusy = 0;
      nvalid = 0;
      for (int i = 0; i < 60; i++) begin
         if (busy) nbusy++;
         if (card_valid) nvalid++;
         @(negedge clk);
      end
      check("pri_busy_cycles", nbusy, 52);
      check("pri_no_valid", nvalid, 0);
      check("pri_left", cards_left, 52);
      check("pri_rank", card_rank, 5);
      check("pri_suit", card_suit, saved_suit);
      $display("[TB] shuffle priority busy=%0d valid=%0d left=%0d", nbusy, nvalid, cards_left);

      // Request during SEARCH is ignored
      card_req = 1'b1;
      @(negedge clk);
      check("ign_busy", busy, 1);
      nvalid = 0;
      for (int i = 0; i < 10; i++) begin
         card_req = (i == 0);
         if (card_valid) nvalid++;
         @(negedge clk);
      end
      card_req = 1'b0;
      check("ign_one_valid", nvalid, 1);
      check("ign_left", cards_left, 51);
      check("ign_rank", card_rank, 1);
      $display("[TB] ignored request valid=%0d left=%0d", nvalid, cards_left);

      // Async reset in SHUFFLE cycle 20
      deal(lat);
      check("ar_pre_rank", card_rank, 2);
      @(negedge clk);
      shuffle = 1'b1;
      @(negedge clk);
      shuffle = 1'b0;
      repeat (19) @(negedge clk);
      check("ar_busy_pre", busy, 1);
      #2;
      reset = 1'b0;
      #1;
      check("ar_busy", busy, 0);
      check("ar_valid", card_valid, 0);
      check("ar_rank", card_rank, 0);
      check("ar_value", card_value, 0);
      check("ar_suit", card_suit, 0);
      check("ar_left", cards_left, 52);
      check("ar_need", need_shuffle, 0);
      @(negedge clk);
      reset = 1'b1;
      deal(lat);
      check("ar_deal_lat", lat, 2);
      check("ar_deal_rank", card_rank, 1);
      check("ar_deal_suit", card_suit, 0);
      check("ar_deal_left", cards_left, 51);
      $display("[TB] after async reset rank=%0d suit=%0d left=%0d", card_rank, card_suit, cards_left);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
